// File: rtl/disp_pkg.sv
// Shared constants for the display scanner: active-low 7-segment codes (a..g,
// index 0 = a) and the slot phase type.
package disp_pkg;

  localparam logic [0:6] SEG_0   = 7'b0000001;
  localparam logic [0:6] SEG_1   = 7'b1001111;
  localparam logic [0:6] SEG_2   = 7'b0010010;
  localparam logic [0:6] SEG_3   = 7'b0000110;
  localparam logic [0:6] SEG_4   = 7'b1001100;
  localparam logic [0:6] SEG_5   = 7'b0100100;
  localparam logic [0:6] SEG_6   = 7'b0100000;
  localparam logic [0:6] SEG_7   = 7'b0001111;
  localparam logic [0:6] SEG_8   = 7'b0000000;
  localparam logic [0:6] SEG_9   = 7'b0000100;
  localparam logic [0:6] SEG_A   = 7'b0001000;
  localparam logic [0:6] SEG_B   = 7'b1100000;
  localparam logic [0:6] SEG_C   = 7'b0110001;
  localparam logic [0:6] SEG_D   = 7'b1000010;
  localparam logic [0:6] SEG_E   = 7'b0110000;
  localparam logic [0:6] SEG_F   = 7'b0111000;
  localparam logic [0:6] SEG_OFF = 7'b1111111;

  typedef enum logic {DEAD, SHOW} phase_t;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [0:6] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    unique case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scanner with per-slot blanking, frame snapshot and
// leading-zero suppression. Optional decimal point when DISP_DP_EN is defined.
module display_scan_mux
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 256,
  parameter int DEAD_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    blank_lz,
`ifdef DISP_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp,
`endif
  output logic [0:6]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]        r_div_cnt;
  logic [DIG_W-1:0]        r_dig;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic                    r_blank_lz;

  logic                    w_frame_start;
  logic [4*NUM_DIGITS-1:0] w_data;
  logic                    w_blank_en;
  phase_t                  w_phase;
  logic [3:0]              w_nibble;
  logic                    w_lz_dark;
  logic [0:6]              w_seg;
  logic [NUM_DIGITS-1:0]   w_an_on;

  // On the frame-start cycle the snapshot is still being loaded, so the live
  // inputs stand in for it (only visible when DEAD_CYCLES is 0).
  assign w_frame_start = en && (r_div_cnt == '0) && (r_dig == '0);
  assign w_data        = w_frame_start ? data_in  : r_snap;
  assign w_blank_en    = w_frame_start ? blank_lz : r_blank_lz;
  assign w_phase       = (r_div_cnt < CNT_W'(DEAD_CYCLES)) ? DEAD : SHOW;
  assign w_an_on       = ~(NUM_DIGITS'(1) << r_dig);

  always_comb begin
    w_nibble  = '0;
    w_lz_dark = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (int'(r_dig) == k) begin
        w_nibble  = w_data[4*k +: 4];
        w_lz_dark = w_blank_en && (k != 0) && ((w_data >> (4*k)) == '0);
      end
    end
  end

  hex7seg u_hex7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

`ifdef DISP_DP_EN
  logic [NUM_DIGITS-1:0] r_dp_snap;
  logic [NUM_DIGITS-1:0] w_dp_data;
  logic                  w_dp_bit;

  assign w_dp_data = w_frame_start ? dp_in : r_dp_snap;

  always_comb begin
    w_dp_bit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (int'(r_dig) == k) w_dp_bit = w_dp_data[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dp_snap <= '0;
      dp        <= 1'b1;
    end else if (!en) begin
      dp        <= 1'b1;
    end else begin
      if (w_frame_start) r_dp_snap <= dp_in;
      dp <= (w_phase == SHOW && !w_lz_dark) ? ~w_dp_bit : 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt  <= '0;
      r_dig      <= '0;
      r_snap     <= '0;
      r_blank_lz <= 1'b0;
      an         <= '1;
      seg        <= SEG_OFF;
      frame_tick <= 1'b0;
    end else if (!en) begin
      r_div_cnt  <= '0;
      r_dig      <= '0;
      an         <= '1;
      seg        <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= w_frame_start;
      if (w_frame_start) begin
        r_snap     <= data_in;
        r_blank_lz <= blank_lz;
      end
      if (r_div_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        r_div_cnt <= '0;
        r_dig     <= (r_dig == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_dig + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (w_phase == SHOW && !w_lz_dark) begin
        an  <= w_an_on;
        seg <= w_seg;
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed + random bench for display_scan_mux (4 digits, 16-cycle slots, 2 dead
// cycles) against a time-based reference model of the scan.
module tb_display_scan_mux;

  localparam int ND   = 4;
  localparam int DIV  = 16;
  localparam int DEAD = 2;
  localparam int FRAME = ND * DIV;

  logic          clk;
  logic          rst;
  logic          en;
  logic [4*ND-1:0] data_in;
  logic          blank_lz;
  logic [0:6]    seg;
  logic [ND-1:0] an;
  logic          frame_tick;
`ifdef DISP_DP_EN
  logic [ND-1:0] dp_in;
  logic          dp;
  logic [ND-1:0] m_dp;
  logic          e_dp;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: enabled-cycle position within the frame
  int            m_t;
  logic [4*ND-1:0] m_snap;
  logic          m_blank;
  logic [6:0]    e_seg;
  logic [ND-1:0] e_an;
  logic          e_ft;
  logic [6:0]    seg_tab [16];

  display_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .DEAD_CYCLES(DEAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data_in    (data_in),
    .blank_lz   (blank_lz),
`ifdef DISP_DP_EN
    .dp_in      (dp_in),
    .dp         (dp),
`endif
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  function automatic bit lz_dark(input int d);
    int h;
    h = -1;
    for (int k = 0; k < ND; k++) if (m_snap[4*k +: 4] != 4'h0) h = k;
    return m_blank && (d > 0) && (d > h);
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".an"}, 32'(an), 32'(e_an));
    chk({tag, ".seg"}, 32'(seg), 32'(e_seg));
    chk({tag, ".ft"}, 32'(frame_tick), 32'(e_ft));
`ifdef DISP_DP_EN
    chk({tag, ".dp"}, 32'(dp), 32'(e_dp));
`endif
  endtask

  // Predict the outputs the coming edge will produce, clock it, check at negedge.
  task automatic step(input string tag);
    int pos, d;
    bit dark;
    if (!en) begin
      m_t  = 0;
      e_an = '1; e_seg = 7'h7F; e_ft = 1'b0;
`ifdef DISP_DP_EN
      e_dp = 1'b1;
`endif
    end else begin
      pos = m_t % DIV;
      d   = m_t / DIV;
      e_ft = (m_t == 0);
      if (m_t == 0) begin
        m_snap  = data_in;
        m_blank = blank_lz;
`ifdef DISP_DP_EN
        m_dp    = dp_in;
`endif
      end
      dark  = (pos < DEAD) || lz_dark(d);
      e_an  = dark ? '1 : ~(ND'(1) << d);
      e_seg = dark ? 7'h7F : seg_tab[m_snap[4*d +: 4]];
`ifdef DISP_DP_EN
      e_dp  = dark ? 1'b1 : ~m_dp[d];
`endif
      m_t = (m_t + 1) % FRAME;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic run_to(input string tag, input int target);
    int budget;
    budget = 2 * FRAME;
    while (m_t != target && budget > 0) begin
      step(tag);
      budget--;
    end
    chk({tag, ".reach"}, 32'(m_t), 32'(target));
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    rst = 1'b0; en = 1'b0; data_in = '0; blank_lz = 1'b0;
    m_t = 0; m_snap = '0; m_blank = 1'b0;
`ifdef DISP_DP_EN
    dp_in = 4'b0100; m_dp = '0; e_dp = 1'b1;
`endif
    e_an = '1; e_seg = 7'h7F; e_ft = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check_outputs("reset");

    // scan order with 1A3F
    rst = 1'b1; en = 1'b1; data_in = 16'h1A3F;
    run("scan", 2 * FRAME);

    // no tearing: change data mid-frame
    data_in = 16'h1234;
    run_to("tear_a", 0);
    run_to("tear_b", 24);
    data_in = 16'h5678;
    run("tear_c", FRAME + 8);

    // leading-zero blanking
    blank_lz = 1'b1; data_in = 16'h0040;
    run_to("lz_a", 0);
    run("lz_40", FRAME);
    data_in = 16'h0000;
    run("lz_00", FRAME);
    blank_lz = 1'b0;

    // enable gating mid-frame
    data_in = 16'h9C0E;
    run_to("en_a", 20);
    en = 1'b0;
    run("en_off", 10);
    en = 1'b1;
    run("en_on", FRAME + 4);

    // asynchronous reset during digit 2 SHOW
    data_in = 16'hBD27;
    run_to("rst_a", 0);
    run_to("rst_b", 2 * DIV + 6);
    #2 rst = 1'b0;
    #1;
    m_t = 0; m_snap = '0; m_blank = 1'b0;
`ifdef DISP_DP_EN
    m_dp = '0;
    e_dp = 1'b1;
`endif
    e_an = '1; e_seg = 7'h7F; e_ft = 1'b0;
    check_outputs("rst_async");
    @(negedge clk);
    check_outputs("rst_hold");
    rst = 1'b1;
    run("rst_after", FRAME + 4);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) data_in = 16'($urandom);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 3) == 0 && data_in[15:8] != 8'h00) data_in[15:8] = 8'h00;
`ifdef DISP_DP_EN
      if ($urandom_range(0, 29) == 0) dp_in = 4'($urandom);
`endif
      en = ($urandom_range(0, 149) != 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits; legal range 1..8.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 256, meaning clk cycles per digit slot; it SHALL be greater than DEAD_CYCLES+1.
REQ-003 The block SHALL have parameter DEAD_CYCLES, default 8, meaning the anti-ghosting blank cycles at the start of each slot; legal range 0..REFRESH_DIV-2.
REQ-004 The block SHALL have port clk, input, width 1: the single clock, rising-edge.
REQ-005 The block SHALL have port rst, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, width 1: scan enable.
REQ-007 The block SHALL have port data_in, input, width 4*NUM_DIGITS: hex nibbles, with digit k in bits [4k+3:4k].
REQ-008 The block SHALL have port blank_lz, input, width 1: leading-zero blanking enable.
REQ-009 The block SHALL have port seg, output, width 7, indexed [0:6] (a..g): segment drive, active-low.
REQ-010 The block SHALL have port an, output, width NUM_DIGITS: anode drive, active-low, one-hot-or-none.
REQ-011 The block SHALL have port frame_tick, output, width 1: a one-cycle pulse at each frame start.

Function
REQ-012 The block SHALL keep slot counter div_cnt, running 0..REFRESH_DIV-1 and wrapping to 0, and digit index dig, running 0..NUM_DIGITS-1; dig SHALL increment when div_cnt = REFRESH_DIV-1 and SHALL wrap from NUM_DIGITS-1 to 0.
REQ-013 The block SHALL define two slot phases: DEAD while div_cnt < DEAD_CYCLES, and SHOW otherwise.
REQ-014 A frame start SHALL occur when en=1, div_cnt=0 and dig=0; on that cycle the block SHALL copy data_in into the frame snapshot and assert frame_tick high for exactly that cycle.
REQ-015 Only the snapshot SHALL be displayed, so that changes to data_in mid-frame cause no tearing.
REQ-016 seg, an and frame_tick SHALL all be registered; seg and an SHALL reflect the div_cnt and dig values of the previous cycle (1-cycle latency).
REQ-017 In the DEAD phase, an SHALL be all ones and seg SHALL be 7'b1111111.
REQ-018 In the SHOW phase, an[dig] SHALL be 0, all other anode bits SHALL be 1, and seg SHALL be the encoding of snapshot digit dig.
REQ-019 The segment encoding SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-020 Leading-zero blanking: when blank_lz=1, every snapshot digit above the highest nonzero digit SHALL show seg all ones and an all ones during its SHOW phase; digit 0 SHALL never be blanked.
REQ-021 blank_lz SHALL be sampled together with the snapshot at frame start.
REQ-022 When en=0, div_cnt and dig SHALL be held at 0, an SHALL be all ones, seg SHALL be all ones, and frame_tick SHALL be 0.
REQ-023 When en rises, the first frame start SHALL occur on the first cycle with en=1.
REQ-024 When NUM_DIGITS=1, dig SHALL stay at 0 and a frame start SHALL occur every REFRESH_DIV cycles.

Reset
REQ-025 While rst=0, div_cnt, dig and the snapshot SHALL be 0, an SHALL be all ones, seg SHALL be 7'b1111111, and frame_tick SHALL be 0, all asynchronously.
REQ-026 On reset deassertion, the block SHALL resume at div_cnt=0, dig=0; a reset asserted mid-slot SHALL abort the slot with no partial pulse.

Configuration
REQ-027 With macro DISP_DP_EN defined, the block SHALL add input dp_in (width NUM_DIGITS) and output dp (width 1, active-low).
REQ-028 With DISP_DP_EN defined, dp_in SHALL be snapshotted with data_in, and dp SHALL be ~dp_snap[dig] in SHOW and 1 in DEAD, when blanked and in reset.
REQ-029 Without DISP_DP_EN, neither dp_in nor dp SHALL exist, and no decimal-point logic SHALL be generated.

Structure
REQ-030 Package disp_pkg SHALL hold the 16 segment encoding constants, the SEG_OFF constant (7'b1111111) and the phase enum {DEAD, SHOW}.
REQ-031 Combinational sub-module hex7seg SHALL map a 4-bit nibble to the 7-bit seg code from disp_pkg and SHALL be instantiated once.

Verification
REQ-032 Scenario, scan order: NUM_DIGITS=4, REFRESH_DIV=16, DEAD_CYCLES=2, data_in=16'h1A3F, en=1 -> an cycles 1110, 1101, 1011, 0111 with seg F, 3, A, 1, each preceded by 2 cycles of an=1111; frame_tick every 64 cycles.
REQ-033 Scenario, no tearing: change data_in from 16'h1234 to 16'h5678 mid-frame -> the remaining digits of that frame still show 1234 digits; 5678 appears from the next frame_tick.
REQ-034 Scenario, leading zeros: blank_lz=1, data_in=16'h0040 -> digits 3 and 2 dark, digit 1 shows 4, digit 0 shows 0; data_in=16'h0000 -> only digit 0 lit, showing 0.
REQ-035 Scenario, reset mid-slot: assert rst=0 during the SHOW phase of digit 2 -> an=1111, seg=1111111 in the same cycle; after release, the first frame_tick occurs 1 cycle later and digit 0 is shown first.
REQ-036 Scenario, enable gating: drop en for 10 cycles mid-frame -> outputs dark, no frame_tick; on re-enable, frame_tick fires immediately and the scan restarts at digit 0.
REQ-037 Scenario, decimal point: with DISP_DP_EN, dp_in=4'b0100 -> dp=0 only during the SHOW phase of digit 2, and dp=1 in all DEAD phases.
